dsi_packet_assembler: RTL and testbench

- Upstream neighbour of the DSI lane serializer; runs in the clk_base domain.
- Accepts a packet descriptor (data ID, word count, long/short, HS/LP, dummy) plus a byte-wide payload stream.
- Emits header bytes, the ECC byte, payload, and CRC-16 as a byte stream on the lane's data_write/data_request interface.
- Flags the last byte with end_of_frame so the lane returns to LP after each burst.

---
 rtl/dsi_pkg.sv | 32 +++
 rtl/dsi_ecc_crc.sv | 44 ++++
 rtl/dsi_packet_assembler.sv | 162 ++++++++++++++++
 tb/tb_dsi_packet_assembler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_pkg.sv
// Shared state encodings, DSI constants and ECC masks for the DSI packet assembler.
// DSI_ASM_EOT_EN adds the EoT trailer state.
package dsi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CRC_LO  = 3'd3,
      ST_CRC_HI  = 3'd4,
      ST_DUMMY   = 3'd5
`ifdef DSI_ASM_EOT_EN
      , ST_EOT   = 3'd6
`endif
   } state_t;

   localparam logic [7:0]  DT_SHORT_WRITE = 8'h05;
   localparam logic [7:0]  DT_LONG_WRITE  = 8'h39;
   localparam logic [7:0]  DT_EOT         = 8'h08;

   // EoT short packet, byte 0 in the low bits: 0x08, 0x0F, 0x0F, 0x01.
   localparam logic [31:0] EOT_PKT        = {8'h01, 8'h0F, 8'h0F, DT_EOT};

   localparam logic [15:0] CRC_POLY_REFL  = 16'h8408;

   // Hamming parity masks over {WC[15:8], WC[7:0], DI}; entry i produces ECC[i].
   localparam logic [5:0][23:0] ECC_MASK = {
      24'hEFFC00, 24'hDF03F0, 24'hB8E38E,
      24'h749A6D, 24'hF2555B, 24'hF12CB7
   };

endpackage

// File: rtl/dsi_ecc_crc.sv
// Header ECC (combinational) and running CRC-16/CCITT (reflected) for the packet assembler.
module dsi_ecc_crc
   import dsi_pkg::*;
#(
   parameter logic [15:0] CRC_SEED = 16'hFFFF
) (
   input  logic        clk_base,
   input  logic        reset_n,
   input  logic [23:0] ecc_data,
   output logic [7:0]  ecc,
   input  logic        crc_seed,
   input  logic        crc_en,
   input  logic [7:0]  crc_byte,
   output logic [15:0] crc
);

   function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r[0] ^ b[i]) ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
      end
      return r;
   endfunction

   always_comb begin
      // NOTE: assign a default before any conditional/loop writes so no latch is inferred.
      ecc = 8'h00;
      for (int i = 0; i < 6; i++) begin
         ecc[i] = ^(ecc_data & ECC_MASK[i]);
      end
   end

   always_ff @(posedge clk_base or negedge reset_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n)
         crc <= 16'h0000;
      else if (crc_seed)
         crc <= CRC_SEED;
      else if (crc_en)
         crc <= crc_next(crc, crc_byte);
   end

endmodule

// File: rtl/dsi_packet_assembler.sv
// Builds DSI packets (DI, WC, ECC, payload, CRC-16) as a byte stream for the lane serializer.
// Define DSI_ASM_EOT_EN to append an EoT short packet after every non-dummy HS packet.
module dsi_packet_assembler
   import dsi_pkg::*;
#(
   parameter int          WC_W     = 16,
   parameter logic [15:0] CRC_SEED = 16'hFFFF
) (
   input  logic            clk_base,
   input  logic            reset_n,
   input  logic            pkt_valid,
   output logic            pkt_ready,
   input  logic [7:0]      pkt_data_id,
   input  logic [WC_W-1:0] pkt_word_count,
   input  logic            pkt_long,
   input  logic            pkt_hs,
   input  logic            pkt_dummy,
   input  logic [7:0]      payload_data,
   input  logic            payload_valid,
   output logic            payload_ready,
   input  logic            data_request,
   output logic            data_write,
   output logic [7:0]      data_input,
   output logic            data_type,
   output logic            end_of_frame,
   output logic            dummy_frame,
   output logic            underrun_err,
   output logic            busy
);

   localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

   state_t          state;
   state_t          done_state;
   logic [1:0]      idx;
   logic [WC_W-1:0] wc_q;
   logic [WC_W-1:0] remaining;
   logic [7:0]      di_q;
   logic [7:0]      ecc_q;
   logic [7:0]      ecc;
   logic [7:0]      byte_mux;
   logic [15:0]     crc;
   logic            long_q;
   logic            hs_q;
   logic            last_byte;
   logic            eof_mux;

   dsi_ecc_crc #(.CRC_SEED(CRC_SEED)) u_ecc_crc (
      .clk_base (clk_base),
      .reset_n  (reset_n),
      .ecc_data ({pkt_word_count, pkt_data_id}),
      .ecc      (ecc),
      .crc_seed (pkt_valid && pkt_ready),
      .crc_en   (data_write && (state == ST_PAYLOAD)),
      .crc_byte (byte_mux),
      .crc      (crc)
   );

   always_comb begin
      byte_mux  = 8'h00;
      last_byte = 1'b0;
      case (state)
         ST_HDR: begin
            case (idx)
               2'd0:    byte_mux = di_q;
               2'd1:    byte_mux = wc_q[7:0];
               2'd2:    byte_mux = wc_q[15:8];
               default: byte_mux = ecc_q;
            endcase
            last_byte = (idx == 2'd3) && !long_q;
         end
         // A missing payload byte is replaced by filler so the HS burst never stalls.
         ST_PAYLOAD: byte_mux = payload_valid ? payload_data : 8'h00;
         ST_CRC_LO:  byte_mux = crc[7:0];
         ST_CRC_HI: begin
            byte_mux  = crc[15:8];
            last_byte = 1'b1;
         end
         ST_DUMMY:   last_byte = 1'b1;
`ifdef DSI_ASM_EOT_EN
         ST_EOT:     byte_mux = EOT_PKT[{idx, 3'b000} +: 8];
`endif
         default: ;
      endcase
`ifdef DSI_ASM_EOT_EN
      // The EoT trailer follows real HS packets only, never the dummy frame.
      done_state = (hs_q && (state != ST_DUMMY)) ? ST_EOT : ST_IDLE;
      eof_mux    = (last_byte && (done_state == ST_IDLE)) || ((state == ST_EOT) && (idx == 2'd3));
`else
      done_state = ST_IDLE;
      eof_mux    = last_byte;
`endif
   end

   assign pkt_ready     = (state == ST_IDLE);
   assign busy          = (state != ST_IDLE);
   assign data_write    = busy && data_request;
   assign data_input    = data_write ? byte_mux : 8'h00;
   assign data_type     = data_write && hs_q;
   assign end_of_frame  = data_write && eof_mux;
   assign dummy_frame   = data_write && (state == ST_DUMMY);
   assign payload_ready = (state == ST_PAYLOAD) && data_request && payload_valid;

   always_ff @(posedge clk_base or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         idx          <= 2'd0;
         wc_q         <= '0;
         remaining    <= '0;
         di_q         <= 8'h00;
         ecc_q        <= 8'h00;
         long_q       <= 1'b0;
         hs_q         <= 1'b0;
         underrun_err <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (pkt_valid) begin
            di_q         <= pkt_data_id;
            wc_q         <= pkt_word_count;
            remaining    <= pkt_word_count;
            long_q       <= pkt_long;
            hs_q         <= pkt_hs;
            ecc_q        <= ecc;
            idx          <= 2'd0;
            underrun_err <= 1'b0;
            state        <= pkt_dummy ? ST_DUMMY : ST_HDR;
         end
      end else if (data_write) begin
         if ((state == ST_PAYLOAD) && !payload_valid)
            underrun_err <= 1'b1;
         case (state)
            ST_HDR: begin
               idx <= idx + 2'd1;
               if (idx == 2'd3) begin
                  if (!long_q)
                     state <= done_state;
                  else if (wc_q == '0)
                     state <= ST_CRC_LO;
                  else
                     state <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               remaining <= remaining - WC_ONE;
               if (remaining == WC_ONE)
                  state <= ST_CRC_LO;
            end
            ST_CRC_LO: state <= ST_CRC_HI;
            ST_CRC_HI: state <= done_state;
            ST_DUMMY:  state <= ST_IDLE;
`ifdef DSI_ASM_EOT_EN
            ST_EOT: begin
               idx <= idx + 2'd1;
               if (idx == 2'd3)
                  state <= ST_IDLE;
            end
`endif
            default:   state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// Self-checking bench for dsi_packet_assembler: table-driven packets plus a mid-payload reset sequence.
module tb_dsi_packet_assembler;

   typedef struct {
      logic [7:0]  di;
      logic [15:0] wc;
      logic        lng;
      logic        hs;
      logic        dmy;
      logic [7:0]  ecc;       // hand-computed header ECC
      int          req_mode;  // 0: data_request held 1, 1: toggles 1,0,1,...
      int          under_at;  // payload index driven with payload_valid=0, -1 for none
   } vec_t;

   logic        clk_base;
   logic        reset_n;
   logic        pkt_valid;
   logic        pkt_ready;
   logic [7:0]  pkt_data_id;
   logic [15:0] pkt_word_count;
   logic        pkt_long;
   logic        pkt_hs;
   logic        pkt_dummy;
   logic [7:0]  payload_data;
   logic        payload_valid;
   logic        payload_ready;
   logic        data_request;
   logic        data_write;
   logic [7:0]  data_input;
   logic        data_type;
   logic        end_of_frame;
   logic        dummy_frame;
   logic        underrun_err;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   vec_t vecs [6];
   vec_t rst_vec;

   dsi_packet_assembler dut (
      .clk_base       (clk_base),
      .reset_n        (reset_n),
      .pkt_valid      (pkt_valid),
      .pkt_ready      (pkt_ready),
      .pkt_data_id    (pkt_data_id),
      .pkt_word_count (pkt_word_count),
      .pkt_long       (pkt_long),
      .pkt_hs         (pkt_hs),
      .pkt_dummy      (pkt_dummy),
      .payload_data   (payload_data),
      .payload_valid  (payload_valid),
      .payload_ready  (payload_ready),
      .data_request   (data_request),
      .data_write     (data_write),
      .data_input     (data_input),
      .data_type      (data_type),
      .end_of_frame   (end_of_frame),
      .dummy_frame    (dummy_frame),
      .underrun_err   (underrun_err),
      .busy           (busy)
   );

   initial begin
      clk_base = 1'b0;
      forever #5 clk_base = ~clk_base;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] pay_byte(input int j);
      return 8'(j * 37 + 5);
   endfunction

   // Reference CRC-16/CCITT reflected (0x8408), byte folded in first, then 8 shifts.
   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {8'h00, b};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
      return r;
   endfunction

   // Record layout: {data[7:0], end_of_frame, dummy_frame, data_type}.
   task automatic run_pkt(input int id, input vec_t v, input int stop_after);
      logic [10:0] got [$];
      logic [10:0] exp [$];
      logic [10:0] last;
      logic [7:0]  hdr [4];
      logic [7:0]  b;
      logic [15:0] crc;
      int          n_wr, pay_idx, prd_cnt, viol, cyc, j, exp_prd;
      bit          done;
      n_wr = 0; pay_idx = 0; prd_cnt = 0; viol = 0; cyc = 0; j = 0; done = 1'b0;

      if (v.dmy) begin
         exp.push_back({8'h00, 1'b1, 1'b1, v.hs});
      end else begin
         hdr[0] = v.di; hdr[1] = v.wc[7:0]; hdr[2] = v.wc[15:8]; hdr[3] = v.ecc;
         for (int k = 0; k < 4; k++)
            exp.push_back({hdr[k], (k == 3) && !v.lng, 1'b0, v.hs});
         if (v.lng) begin
            crc = 16'hFFFF;
            for (int k = 0; k < int'(v.wc); k++) begin
               if (k == v.under_at) b = 8'h00;
               else begin b = pay_byte(j); j++; end
               crc = crc_upd(crc, b);
               exp.push_back({b, 1'b0, 1'b0, v.hs});
            end
            exp.push_back({crc[7:0], 1'b0, 1'b0, v.hs});
            exp.push_back({crc[15:8], 1'b1, 1'b0, v.hs});
         end
`ifdef DSI_ASM_EOT_EN
         if (v.hs) begin
            last = exp.pop_back();
            last[2] = 1'b0;
            exp.push_back(last);
            exp.push_back({8'h08, 1'b0, 1'b0, 1'b1});
            exp.push_back({8'h0F, 1'b0, 1'b0, 1'b1});
            exp.push_back({8'h0F, 1'b0, 1'b0, 1'b1});
            exp.push_back({8'h01, 1'b1, 1'b0, 1'b1});
         end
`endif
      end

      @(posedge clk_base); #1;
      pkt_valid      = 1'b1;
      pkt_data_id    = v.di;
      pkt_word_count = v.wc;
      pkt_long       = v.lng;
      pkt_hs         = v.hs;
      pkt_dummy      = v.dmy;
      data_request   = 1'b0;
      @(negedge clk_base);
      check($sformatf("v%0d_pkt_ready_idle", id), pkt_ready, 1);

      while (!done && cyc < 200) begin
         @(posedge clk_base); #1;
         // Junk descriptor offered mid-header must be ignored while busy.
         pkt_valid = !v.dmy && (n_wr == 1 || n_wr == 2);
         if (pkt_valid) begin
            pkt_data_id = 8'hEE; pkt_word_count = 16'hBEEF; pkt_dummy = 1'b1; pkt_long = 1'b0;
         end
         data_request  = (v.req_mode == 0) ? 1'b1 : (cyc % 2 == 0);
         payload_valid = !(v.lng && v.under_at >= 0 && n_wr == 4 + v.under_at);
         payload_data  = pay_byte(pay_idx);
         @(negedge clk_base);
         if (data_write && !data_request) viol++;
         if (payload_ready && !data_request) viol++;
         if (payload_ready) begin pay_idx++; prd_cnt++; end
         if (data_write) begin
            got.push_back({data_input, end_of_frame, dummy_frame, data_type});
            n_wr++;
            done = end_of_frame;
         end
         if (stop_after >= 0 && n_wr >= stop_after) return;
         cyc++;
      end

      if (!done) begin
         checks++; failures++;
         $display("FAIL v%0d_timeout: got no end_of_frame expected one within 200 cycles", id);
      end
      check($sformatf("v%0d_length", id), got.size(), exp.size());
      for (int k = 0; k < exp.size() && k < got.size(); k++)
         check($sformatf("v%0d_byte%0d", id, k), {21'd0, got[k]}, {21'd0, exp[k]});
      check($sformatf("v%0d_write_without_request", id), viol, 0);
      exp_prd = (v.lng && !v.dmy) ? int'(v.wc) - ((v.under_at >= 0) ? 1 : 0) : 0;
      check($sformatf("v%0d_payload_ready_count", id), prd_cnt, exp_prd);
      check($sformatf("v%0d_underrun_err", id), underrun_err, v.under_at >= 0);

      @(posedge clk_base); #1;
      data_request = 1'b0;
      pkt_valid    = 1'b0;
      @(negedge clk_base);
      check($sformatf("v%0d_idle_after", id), {pkt_ready, busy}, 2'b10);
   endtask

   initial begin
      //          di     wc        lng   hs    dmy   ecc    req under
      vecs[0] = '{8'h01, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h07, 0, -1};
      vecs[1] = '{8'h39, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h0F, 0, -1};
      vecs[2] = '{8'h05, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h0B, 1, -1};
      vecs[3] = '{8'h39, 16'h0003, 1'b1, 1'b1, 1'b0, 8'h09, 1, -1};
      vecs[4] = '{8'h29, 16'h0002, 1'b1, 1'b0, 1'b0, 8'h00, 0,  1};
      vecs[5] = '{8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h00, 0, -1};
      rst_vec = '{8'h39, 16'h0005, 1'b1, 1'b1, 1'b0, 8'h00, 0, -1};

      reset_n        = 1'b0;
      pkt_valid      = 1'b0;
      pkt_data_id    = 8'h00;
      pkt_word_count = 16'h0000;
      pkt_long       = 1'b0;
      pkt_hs         = 1'b0;
      pkt_dummy      = 1'b0;
      payload_data   = 8'h00;
      payload_valid  = 1'b0;
      data_request   = 1'b1;

      #12;
      check("reset_data_write", data_write, 0);
      check("reset_pkt_ready_busy", {pkt_ready, busy}, 2'b10);
      check("reset_flags", {end_of_frame, dummy_frame, data_type, underrun_err, payload_ready}, 5'b0);
      @(negedge clk_base);
      reset_n      = 1'b1;
      data_request = 1'b0;

      for (int i = 0; i < 6; i++)
         run_pkt(i, vecs[i], -1);

      // Reset in the middle of a payload: outputs drop at once, next packet starts clean.
      run_pkt(6, rst_vec, 6);
      @(posedge clk_base); #1;
      reset_n      = 1'b0;
      data_request = 1'b1;
      #1;
      check("midreset_data_write", data_write, 0);
      check("midreset_pkt_ready_busy", {pkt_ready, busy}, 2'b10);
      check("midreset_outputs", {data_input, end_of_frame, payload_ready}, 10'd0);
      @(negedge clk_base);
      reset_n      = 1'b1;
      data_request = 1'b0;
      run_pkt(7, vecs[3], -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
